// File: rtl/eth_rx_framer.sv
// rtl/eth_rx_framer.sv - MAC byte stream to length-prefixed 32-bit frame stream via circular halfword buffer
// Optional saturating drop counter port: define ETH_RX_DROP_STATS_EN.
module eth_rx_framer #(
  parameter int ADDR_W = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        rx_last,
  input  logic        rx_error,
  output logic [31:0] output_eth_rx,
  output logic        output_eth_rx_stb,
  input  logic        output_eth_rx_ack
`ifdef ETH_RX_DROP_STATS_EN
  ,
  output logic [15:0] drop_count
`endif
);
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_COMMIT} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_LEN, R_DATA} rstate_t;

  wstate_t           wstate;
  rstate_t           rstate;
  logic [15:0]       mem [DEPTH];
  logic [ADDR_W-1:0] commit_ptr, wr_ptr, rd_ptr;
  logic [15:0]       byte_cnt;
  logic [7:0]        hold;
  logic              dropping;
  logic [15:0]       words_left;

  logic              start, accept, bad, odd_beat, data_we, we;
  logic [16:0]       next_cnt, need, free_ext;
  logic [ADDR_W:0]   free_slots;
  logic [ADDR_W-1:0] wr_base, rd_next, waddr;
  logic [15:0]       wdata;

  // A frame in flight is not counted as occupied until commit, so the free
  // space check covers the header slot plus every halfword seen so far.
  always_comb begin
    start      = (wstate != W_DATA);
    accept     = rx_valid && !(wstate == W_DATA && dropping);
    next_cnt   = start ? 17'd1 : {1'b0, byte_cnt} + 17'd1;
    need       = 17'd1 + ((next_cnt + 17'd1) >> 1);
    free_slots = (ADDR_W+1)'(DEPTH - 1) - {1'b0, commit_ptr - rd_ptr};
    free_ext   = 17'(free_slots);
    bad        = rx_error || (wstate == W_COMMIT) || next_cnt[16] || (need > free_ext);
    odd_beat   = !start && byte_cnt[0];
    wr_base    = start ? commit_ptr + ADDR_W'(1) : wr_ptr;
    data_we    = accept && !bad && (odd_beat || rx_last);
    rd_next    = rd_ptr + ADDR_W'(1);
    we         = data_we || (wstate == W_COMMIT);
    waddr      = (wstate == W_COMMIT) ? commit_ptr : wr_base;
    wdata      = (wstate == W_COMMIT) ? byte_cnt :
                 odd_beat ? {hold, rx_data} : {rx_data, 8'h00};
  end

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wstate     <= W_IDLE;
      commit_ptr <= '0;
      wr_ptr     <= '0;
      byte_cnt   <= '0;
      hold       <= '0;
      dropping   <= 1'b0;
    end else begin
      if (wstate == W_COMMIT) begin
        commit_ptr <= wr_ptr;
        wstate     <= W_IDLE;
      end
      if (accept) begin
        byte_cnt <= next_cnt[15:0];
        hold     <= rx_data;
        if (bad) begin
          dropping <= !rx_last;
          wstate   <= rx_last ? W_IDLE : W_DATA;
        end else begin
          dropping <= 1'b0;
          wr_ptr   <= data_we ? wr_base + ADDR_W'(1) : wr_base;
          wstate   <= rx_last ? W_COMMIT : W_DATA;
        end
      end else if (rx_valid && rx_last) begin
        dropping <= 1'b0;
        wstate   <= W_IDLE;
      end
    end
  end

  // words_left == 0 in R_FETCH means the slot at rd_ptr is a frame header.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rstate            <= R_IDLE;
      rd_ptr            <= '0;
      words_left        <= '0;
      output_eth_rx     <= '0;
      output_eth_rx_stb <= 1'b0;
    end else begin
      case (rstate)
        R_IDLE: begin
          if (rd_ptr != commit_ptr) rstate <= R_FETCH;
        end
        R_FETCH: begin
          output_eth_rx     <= {16'h0, mem[rd_ptr]};
          output_eth_rx_stb <= 1'b1;
          rstate            <= (words_left != 16'd0) ? R_DATA : R_LEN;
        end
        R_LEN: begin
          if (output_eth_rx_ack) begin
            output_eth_rx_stb <= 1'b0;
            rd_ptr            <= rd_next;
            words_left        <= 16'((17'(output_eth_rx[15:0]) + 17'd1) >> 1);
            rstate            <= R_FETCH;
          end
        end
        R_DATA: begin
          if (output_eth_rx_ack) begin
            output_eth_rx_stb <= 1'b0;
            rd_ptr            <= rd_next;
            words_left        <= words_left - 16'd1;
            rstate <= (words_left != 16'd1 || rd_next != commit_ptr) ? R_FETCH : R_IDLE;
          end
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

`ifdef ETH_RX_DROP_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) drop_count <= '0;
    else if (accept && bad && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_eth_rx_framer.sv
// tb/tb_eth_rx_framer.sv - directed self-checking bench for eth_rx_framer (ADDR_W=4)
module tb_eth_rx_framer;
  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_last, rx_error;
  logic        ack;
  logic [31:0] out;
  logic        stb;
`ifdef ETH_RX_DROP_STATS_EN
  logic [15:0] drop_count;
`endif

  int          vectors = 0;
  int          miscompares = 0;
  int          lat;
  int          k;
  logic [31:0] rxq[$];
  logic [31:0] expq[$];
  logic [7:0]  txq[$];

  eth_rx_framer #(.ADDR_W(4)) dut (
    .clk               (clk),
    .rst               (rst),
    .rx_data           (rx_data),
    .rx_valid          (rx_valid),
    .rx_last           (rx_last),
    .rx_error          (rx_error),
    .output_eth_rx     (out),
    .output_eth_rx_stb (stb),
    .output_eth_rx_ack (ack)
`ifdef ETH_RX_DROP_STATS_EN
    ,
    .drop_count        (drop_count)
`endif
  );

  always #5 clk = ~clk;

  // stb/ack are stable from the negedge to the transferring posedge
  always @(negedge clk) begin
    if (stb && ack) rxq.push_back(out);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_frame(input int err_idx, input bit with_last);
    for (int i = 0; i < txq.size(); i++) begin
      rx_data  = txq[i];
      rx_valid = 1'b1;
      rx_last  = with_last && (i == txq.size() - 1);
      rx_error = (i == err_idx);
      @(posedge clk); #1;
    end
    rx_valid = 1'b0;
    rx_last  = 1'b0;
    rx_error = 1'b0;
  endtask

  task automatic wait_rx(input int n, input bit settle);
    int c = 0;
    while (rxq.size() < n && c < 400) begin
      @(posedge clk); #1;
      c++;
    end
    if (settle) begin
      repeat (30) @(posedge clk);
      #1;
    end
  endtask

  task automatic check_rx(input string tag);
    check({tag, " count"}, 32'(rxq.size()), 32'(expq.size()));
    for (int i = 0; i < expq.size() && i < rxq.size(); i++)
      check($sformatf("%s w%0d", tag, i), rxq[i], expq[i]);
    rxq.delete();
  endtask

  initial begin
    rst = 1'b0; rx_data = '0; rx_valid = 1'b0; rx_last = 1'b0; rx_error = 1'b0; ack = 1'b1;
    #1;
    check("reset stb", 32'(stb), 32'd0);
    check("reset data", out, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
`ifdef ETH_RX_DROP_STATS_EN
    check("reset drop_count", 32'(drop_count), 32'd0);
`endif
    @(posedge clk); #1;

    // even-length frame and first-word latency
    txq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    send_frame(-1, 1'b1);
    lat = 0;
    k = 1;
    while (lat == 0 && k <= 10) begin
      @(posedge clk); #1;
      if (stb) lat = k;
      k++;
    end
    check("latency", 32'(lat), 32'd3);
    expq = '{32'h6, 32'h0102, 32'h0304, 32'h0506};
    wait_rx(4, 1'b1);
    check_rx("f6");

    // odd-length frame pads low byte
    txq = '{8'hAA, 8'hBB, 8'hCC};
    send_frame(-1, 1'b1);
    expq = '{32'h3, 32'hAABB, 32'hCC00};
    wait_rx(3, 1'b1);
    check_rx("f3");

    // errored frame dropped, clean frame follows
    txq = '{8'h90, 8'h91, 8'h92, 8'h93, 8'h94, 8'h95, 8'h96, 8'h97, 8'h98, 8'h99};
    send_frame(3, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    txq = '{8'h11, 8'h22};
    send_frame(-1, 1'b1);
    expq = '{32'h2, 32'h1122};
    wait_rx(2, 1'b1);
    check_rx("err");
`ifdef ETH_RX_DROP_STATS_EN
    check("drop_count err", 32'(drop_count), 32'd1);
`endif

    // overflow: first 20-byte frame (wraps) kept, second dropped
    ack = 1'b0;
    txq.delete();
    for (int i = 0; i < 20; i++) txq.push_back(8'(8'h40 + i));
    send_frame(-1, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    txq.delete();
    for (int i = 0; i < 20; i++) txq.push_back(8'(8'h80 + i));
    send_frame(-1, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    check("ovf hold stb", 32'(stb), 32'd1);
    check("ovf hold len", out, 32'h14);
`ifdef ETH_RX_DROP_STATS_EN
    check("drop_count ovf", 32'(drop_count), 32'd2);
`endif
    expq.delete();
    expq.push_back(32'h14);
    for (int i = 0; i < 10; i++) expq.push_back({16'h0, 8'(8'h40 + 2*i), 8'(8'h41 + 2*i)});
    ack = 1'b1;
    wait_rx(11, 1'b1);
    check_rx("ovf");

    // ack stalls for 5 cycles on the first data word
    txq = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26};
    send_frame(-1, 1'b1);
    wait_rx(1, 1'b0);
    ack = 1'b0;
    k = 0;
    while (!stb && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("stall stb up", 32'(stb), 32'd1);
    repeat (5) begin
      @(posedge clk); #1;
      check("stall stb", 32'(stb), 32'd1);
      check("stall hold", out, 32'h2122);
    end
    ack = 1'b1;
    expq = '{32'h6, 32'h2122, 32'h2324, 32'h2526};
    wait_rx(4, 1'b1);
    check_rx("stall");

    // asynchronous reset with two frames buffered and one partial
    ack = 1'b0;
    txq = '{8'h31, 8'h32};
    send_frame(-1, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    txq = '{8'h33, 8'h34};
    send_frame(-1, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    txq = '{8'h35, 8'h36};
    send_frame(-1, 1'b0);
    check("pre-rst stb", 32'(stb), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("async rst stb", 32'(stb), 32'd0);
    check("async rst data", out, 32'd0);
    rxq.delete();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    ack = 1'b1;
`ifdef ETH_RX_DROP_STATS_EN
    check("drop_count rst", 32'(drop_count), 32'd0);
`endif
    txq = '{8'h77, 8'h88};
    send_frame(-1, 1'b1);
    expq = '{32'h2, 32'h7788};
    wait_rx(2, 1'b1);
    check_rx("post rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/eth_rx_framer.md
# eth_rx_framer

Receive-side framer between the Ethernet MAC byte interface and the 32-bit `input_eth_rx` stream of `user_design`. Packs received bytes into 16-bit halfwords, buffers each frame in a circular RAM, and releases only complete, error-free frames. Each frame is emitted as a length word followed by its data words, using the stb/ack handshake.

## Interface
- `ADDR_W`, 11: buffer address width. Depth is 2^ADDR_W halfword slots, 4 KB by default.
- `clk` in 1: sole clock. All logic is rising-edge.
- `rst` in 1: asynchronous reset, active-low.
- `rx_data` in 8: MAC received byte.
- `rx_valid` in 1: `rx_data` is valid this cycle. There is no backpressure on this side.
- `rx_last` in 1: qualifies the final byte of a frame. Only meaningful with `rx_valid`.
- `rx_error` in 1: MAC-flagged error (bad FCS, symbol error). Sampled on any valid beat.
- `output_eth_rx` out 32: stream word, connected to `input_eth_rx`.
- `output_eth_rx_stb` out 1: word valid.
- `output_eth_rx_ack` in 1: consumer accepts the word.
- `drop_count` out 16: present only with `ETH_RX_DROP_STATS_EN`.

## Operation
- Write FSM states: W_IDLE, W_DATA, W_COMMIT.
  - W_IDLE: the first `rx_valid` beat starts a frame. The header slot is `commit_ptr`, data starts at `commit_ptr+1`, and the byte count is set to 1.
- Packing:
  - Even-indexed byte goes to halfword[15:8]; odd-indexed byte goes to halfword[7:0].
  - A halfword is written when its odd byte arrives, or on `rx_last`.
  - For odd-length frames, the final halfword's low byte is 0x00.
- Byte count is 16-bit. A frame is dropped if any of these occur:
  - `rx_error` is seen on any beat of the frame.
  - The frame would occupy more than the free space, i.e. more than `depth-1-(commit_ptr-rd_ptr)` slots including the header.
  - The count would exceed 0xFFFF.
- Dropped frames:
  - The data pointer rewinds to `commit_ptr+1` logically. `commit_ptr` is unchanged and nothing reaches the output.
  - Bytes of a dropped frame after the drop decision are discarded until `rx_last`.
- Commit:
  - The `rx_last` beat writes the final halfword.
  - W_COMMIT (one cycle) writes the header word (byte count) into the header slot, then `commit_ptr` advances to the next free slot and the FSM returns to W_IDLE.
  - A valid beat arriving during W_COMMIT starts a new frame that is flagged errored and dropped.
- Read FSM states: R_IDLE, R_FETCH, R_LEN, R_DATA.
  - R_IDLE → R_FETCH when `rd_ptr != commit_ptr`.
  - R_FETCH issues a RAM read (1-cycle latency) into the output register.
  - R_LEN presents `{16'h0, length}` and captures the word count `ceil(length/2)`.
  - R_DATA presents `{16'h0, halfword}` once per data word.
  - After each ack, `rd_ptr` increments. The FSM goes to R_FETCH if words remain or another frame is committed, otherwise to R_IDLE.
- Pointers are ADDR_W bits wide and wrap modulo depth. Frames may straddle the wrap.

## Timing
- Reset values:
  - `output_eth_rx` = 0 and `output_eth_rx_stb` = 0.
  - All pointers = 0; write FSM in W_IDLE, read FSM in R_IDLE.
  - `drop_count` = 0.
- A reset mid-frame discards all buffered and partial frames.
- Latency: `output_eth_rx_stb` rises 3 cycles after the `rx_last` beat for an empty buffer (W_COMMIT, R_FETCH, then presentation).
- Handshake:
  - A word transfers on the rising edge where stb and ack are both 1.
  - While stb=1 and ack=0, `output_eth_rx` holds stable.
  - stb drops for at least one cycle (R_FETCH) between words.
- Peak output rate is one word per 2 cycles. This matches the input peak of one halfword per 2 cycles.
- Commit and read may occur in the same cycle. The reader sees a new `commit_ptr` the cycle after it updates.
- A full buffer never blocks the MAC; it only causes drops.

## Configuration
- `ETH_RX_DROP_STATS_EN` defined:
  - Adds the `drop_count` port: a 16-bit counter that increments once per dropped frame (error, overflow or length), saturating at 0xFFFF.
  - It is cleared only by `rst`.
- Not defined: the port and counter are absent and drops are silent. All other behaviour is identical.

## Test plan
- 6-byte frame 01..06 with ack tied high → words 0x6, 0x0102, 0x0304, 0x0506. First stb occurs 3 cycles after `rx_last`.
- 3-byte frame AA BB CC → words 0x3, 0xAABB, 0xCC00.
- Frame with `rx_error` on byte 4 of 10, followed by a clean 2-byte frame 11 22 → only 0x2, 0x1122 is output, and `drop_count`=1 (macro on).
- `ADDR_W`=4, ack held low, 20-byte frames sent until overflow:
  - The first frame (11 slots) is committed; the second (needs 11 of the 4 remaining slots) is dropped.
  - Releasing ack yields frame 1 intact, including across the pointer wrap.
- Ack low for 5 cycles mid-frame → `output_eth_rx` stays stable and stb stays high throughout, with no duplicated or lost words.
- `rst` asserted mid-frame with 2 frames buffered → stb goes to 0 asynchronously. After release, a new 2-byte frame outputs alone.
